// File: rtl/spectrum_buffer_writer.sv
// spectrum_buffer_writer
//   Collects one frame of 2^ADDR_W unsigned magnitude samples into an external
//   buffer while tracking the frame maximum. After the last sample it pulses
//   adaptation_start_o and waits for adaptation_done_i. It flags a sticky
//   timeout if that pulse does not arrive in time.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   sample_valid_i/_data_i/sample_ready_o   upstream sample handshake
//   write_buffer_addr_o/_data_o/_wen_o      buffer write port, one cycle after transfer
//   adaptation_start_o    one-cycle pulse once the frame is complete
//   max_value_o           frame maximum, held while waiting for the adapter
//   adaptation_done_i     adapter completion pulse
//   timeout_err_o         sticky: adapter did not finish within TIMEOUT_CYCLES
module spectrum_buffer_writer #(
   parameter int DATA_W         = 64,
   parameter int ADDR_W         = 10,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_valid_i,
   input  logic [DATA_W-1:0] sample_data_i,
   output logic              sample_ready_o,
   output logic [ADDR_W-1:0] write_buffer_addr_o,
   output logic [DATA_W-1:0] write_buffer_data_o,
   output logic              write_buffer_wen_o,
   output logic              adaptation_start_o,
   output logic [DATA_W-1:0] max_value_o,
   input  logic              adaptation_done_i,
   output logic              timeout_err_o
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {
      FILL,
      START,
      WAIT_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q;
   logic [TW-1:0]     tcnt_q;
   logic              xfer;
   logic              last_xfer;
   logic              tmo_hit;

   // sample_ready_o is only high in FILL, so a transfer implies FILL
   assign xfer      = sample_valid_i & sample_ready_o;
   assign last_xfer = xfer & (cnt_q == '1);
   assign tmo_hit   = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL:      if (last_xfer) state_d = START;
         START:     state_d = WAIT_DONE;
         WAIT_DONE: if (adaptation_done_i || tmo_hit) state_d = FILL;
         default:   state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q               <= '0;
         tcnt_q              <= '0;
         max_value_o         <= '0;
         sample_ready_o      <= 1'b0;
         write_buffer_wen_o  <= 1'b0;
         write_buffer_addr_o <= '0;
         write_buffer_data_o <= '0;
         adaptation_start_o  <= 1'b0;
         timeout_err_o       <= 1'b0;
      end else begin
         // ready is registered from the next state so it stays low in reset
         // and rises on the first edge after release
         sample_ready_o     <= (state_d == FILL);
         write_buffer_wen_o <= xfer;
         adaptation_start_o <= last_xfer;

         if (xfer) begin
            write_buffer_addr_o <= cnt_q;
            write_buffer_data_o <= sample_data_i;
            cnt_q               <= cnt_q + 1'b1;
            if (sample_data_i > max_value_o) max_value_o <= sample_data_i;
         end

         if (state_q == WAIT_DONE) begin
            // done wins over a simultaneous timeout
            if (adaptation_done_i) begin
               tcnt_q      <= '0;
               max_value_o <= '0;
            end else if (tmo_hit) begin
               tcnt_q        <= '0;
               max_value_o   <= '0;
               timeout_err_o <= 1'b1;
            end else begin
               tcnt_q <= tcnt_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spectrum_buffer_writer.sv
// tb_spectrum_buffer_writer
//   Scoreboard bench for spectrum_buffer_writer. The driver keeps a frame-level
//   reference model and queues the writes and start pulses it expects; an
//   independent monitor pops and compares them whenever the DUT presents them.
module tb_spectrum_buffer_writer;

   localparam int DW    = 64;
   localparam int AW    = 10;
   localparam int TO    = 32;
   localparam int FRAME = 1 << AW;

   localparam int PH_FILL  = 0;
   localparam int PH_START = 1;
   localparam int PH_WAIT  = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sample_valid_i = 1'b0;
   logic [DW-1:0] sample_data_i = '0;
   logic          adaptation_done_i = 1'b0;
   logic          sample_ready_o;
   logic [AW-1:0] write_buffer_addr_o;
   logic [DW-1:0] write_buffer_data_o;
   logic          write_buffer_wen_o;
   logic          adaptation_start_o;
   logic [DW-1:0] max_value_o;
   logic          timeout_err_o;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t           wr_q[$];
   logic [DW-1:0] st_q[$];
   wr_t           mon_e;
   logic [DW-1:0] mon_m;

   int errors = 0;
   int checks = 0;
   int n_wen = 0;
   int n_start = 0;

   // reference model: where we are in the frame life cycle
   int            m_phase = PH_FILL;
   int            m_idx = 0;
   int            m_wait = 0;
   logic [DW-1:0] m_max = '0;
   bit            m_err = 1'b0;
   bit            m_ready = 1'b0;

   always #5 clk = ~clk;

   spectrum_buffer_writer #(
      .DATA_W(DW),
      .ADDR_W(AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sample_valid_i(sample_valid_i),
      .sample_data_i(sample_data_i),
      .sample_ready_o(sample_ready_o),
      .write_buffer_addr_o(write_buffer_addr_o),
      .write_buffer_data_o(write_buffer_data_o),
      .write_buffer_wen_o(write_buffer_wen_o),
      .adaptation_start_o(adaptation_start_o),
      .max_value_o(max_value_o),
      .adaptation_done_i(adaptation_done_i),
      .timeout_err_o(timeout_err_o)
   );

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: compares every presented write / start pulse against the queues
   initial begin
      forever begin
         @(negedge clk);
         if (write_buffer_wen_o) begin
            n_wen++;
            if (wr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr %0d data %h, expected no write", write_buffer_addr_o, write_buffer_data_o);
            end else begin
               mon_e = wr_q.pop_front();
               chk("wr_addr", DW'(write_buffer_addr_o), DW'(mon_e.addr));
               chk("wr_data", write_buffer_data_o, mon_e.data);
            end
         end
         if (adaptation_start_o) begin
            n_start++;
            if (st_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_start: got start pulse max %h, expected none", max_value_o);
            end else begin
               mon_m = st_q.pop_front();
               chk("start_max", max_value_o, mon_m);
            end
         end
      end
   end

   // one clock cycle: check cycle-level outputs, apply inputs, advance the model
   task automatic cycle(input bit v, input logic [DW-1:0] d, input bit dn, output bit xfer);
      wr_t e_w;
      @(negedge clk);
      chk("ready", DW'(sample_ready_o), DW'(m_ready));
      chk("timeout_err", DW'(timeout_err_o), DW'(m_err));
      if (m_phase != PH_FILL) chk("max_hold", max_value_o, m_max);
      sample_valid_i    = v;
      sample_data_i     = d;
      adaptation_done_i = dn;
      xfer = v && m_ready;
      case (m_phase)
         PH_FILL: begin
            if (xfer) begin
               e_w.addr = AW'(m_idx);
               e_w.data = d;
               wr_q.push_back(e_w);
               if (d > m_max) m_max = d;
               m_idx++;
               if (m_idx == FRAME) begin
                  m_idx   = 0;
                  m_phase = PH_START;
                  st_q.push_back(m_max);
               end
            end
         end
         PH_START: begin
            m_phase = PH_WAIT;
            m_wait  = 0;
         end
         default: begin
            m_wait++;
            if (dn) begin
               m_phase = PH_FILL;
               m_max   = '0;
            end else if (m_wait == TO) begin
               m_err   = 1'b1;
               m_phase = PH_FILL;
               m_max   = '0;
            end
         end
      endcase
      m_ready = (m_phase == PH_FILL);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n             = 1'b0;
      sample_valid_i    = 1'b0;
      adaptation_done_i = 1'b0;
      wr_q.delete();
      st_q.delete();
      m_phase = PH_FILL;
      m_idx   = 0;
      m_wait  = 0;
      m_max   = '0;
      m_err   = 1'b0;
      m_ready = 1'b0;
      #1;
      chk("rst_wen", DW'(write_buffer_wen_o), '0);
      chk("rst_addr", DW'(write_buffer_addr_o), '0);
      chk("rst_data", write_buffer_data_o, '0);
      chk("rst_start", DW'(adaptation_start_o), '0);
      chk("rst_err", DW'(timeout_err_o), '0);
      chk("rst_ready", DW'(sample_ready_o), '0);
      chk("rst_max", max_value_o, '0);
      repeat (2) @(negedge clk);
      chk("ready_in_reset", DW'(sample_ready_o), '0);
      rst_n   = 1'b1;
      m_ready = 1'b1;
   endtask

   // kind: 0 data=index, 1 random data/valid, 2 all-zero, 3 toggling valid with all-ones last
   task automatic frame(input int kind, input int done_at, input int stop_at);
      int            sent = 0;
      int            budget = 0;
      bit            x;
      bit            v;
      logic [DW-1:0] d;
      while (sent < stop_at && budget < 4 * FRAME) begin
         case (kind)
            0: begin v = 1'b1; d = DW'(sent); end
            1: begin v = 1'($urandom_range(0, 1)); d = {$urandom, $urandom}; end
            2: begin v = 1'b1; d = '0; end
            default: begin
               v = (budget % 2 == 0);
               d = (sent == FRAME - 1 && v) ? '1 : {$urandom, $urandom};
            end
         endcase
         cycle(v, d, (sent == done_at), x);
         if (x) sent++;
         budget++;
      end
      if (sent < stop_at) begin
         checks++;
         errors++;
         $display("FAIL frame_budget: got %0d transfers, expected %0d", sent, stop_at);
      end
   endtask

   // cycles from the START cycle until back in FILL; done_after<0 never pulses done
   task automatic wait_phase(input int done_after, input bit keep_v);
      int k = 0;
      bit x;
      while (m_phase != PH_FILL && k < 4 * TO) begin
         cycle(keep_v, {$urandom, $urandom}, (k == done_after), x);
         k++;
      end
      if (m_phase != PH_FILL) begin
         checks++;
         errors++;
         $display("FAIL wait_budget: got %0d cycles still waiting, expected return to fill", k);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      int wen0;
      bit x;
      do_reset();
      // back-to-back index frame, valid held high through the wait, done 20 after start
      frame(0, -1, FRAME);
      wait_phase(20, 1'b1);
      // all-zero frame after clear
      frame(2, -1, FRAME);
      wait_phase(3, 1'b0);
      // done during fill is ignored
      frame(0, 500, FRAME);
      wait_phase(5, 1'b0);
      // toggling valid, all-ones at the last index
      wen0 = n_wen;
      frame(3, -1, FRAME);
      wait_phase(2, 1'b1);
      chk("frame_wen_count", DW'(n_wen - wen0), DW'(FRAME));
      // done coincides with the timeout cycle: no error
      frame(1, -1, FRAME);
      wait_phase(TO, 1'b0);
      // no done: timeout, then flag stays set across the next frame
      frame(1, -1, FRAME);
      wait_phase(-1, 1'b1);
      frame(1, -1, FRAME);
      wait_phase(7, 1'b0);
      // reset mid-frame discards it; a full frame is needed afterwards
      frame(0, -1, 700);
      do_reset();
      frame(1, -1, FRAME);
      wait_phase(4, 1'b0);
      repeat (3) cycle(1'b0, '0, 1'b0, x);
      chk("wr_q_empty", DW'(wr_q.size()), '0);
      chk("st_q_empty", DW'(st_q.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
